msrh_l1d_snoop_merge_unit: RTL and testbench
============================================

Name: msrh_l1d_snoop_merge_unit

Overview:
- Sits directly upstream of the LSU top's L1D snoop and STQ snoop ports.
- Accepts one external coherence snoop at a time and issues a single-cycle s0 probe to the L1D and the STQ together.
- Captures both s1 responses and merges STQ pending store bytes over the L1D line bytes.
- Retries on L1D conflict with a fixed backoff, then returns one merged response through a valid/ready handshake.

Parameters:
- PADDR_W, 56, physical address width.
- DATA_W, 128, snoop data width in bits (one L1D read beat); BE width is DATA_W/8.
- BACKOFF, 4, idle cycles between a conflicting probe and the next re-issue.
- RETRY_MAX, 7, maximum re-issues before aborting with CONFLICT status.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_snp_req_valid  in  1  external snoop request valid.
- o_snp_req_ready  out  1  request accepted when valid & ready.
- i_snp_req_paddr  in  PADDR_W  snoop physical address.
- o_l1d_s0_valid  out  1  L1D snoop probe.
- o_l1d_s0_paddr  out  PADDR_W  probe address.
- i_l1d_s1_valid  in  1  L1D response valid.
- i_l1d_s1_status  in  2  L1D status: 0 NONE, 1 HIT, 2 CONFLICT, 3 MISS.
- i_l1d_s1_be  in  DATA_W/8  L1D byte enables.
- i_l1d_s1_data  in  DATA_W  L1D data.
- o_stq_s0_valid  out  1  STQ snoop probe.
- o_stq_s0_paddr  out  PADDR_W  probe address.
- i_stq_s1_valid  in  1  STQ response valid.
- i_stq_s1_be  in  DATA_W/8  STQ pending-store byte enables.
- i_stq_s1_data  in  DATA_W  STQ data.
- o_snp_resp_valid  out  1  merged response valid.
- i_snp_resp_ready  in  1  response consumed.
- o_snp_resp_status  out  2  1 HIT, 2 CONFLICT (aborted), 3 MISS.
- o_snp_resp_be  out  DATA_W/8  merged byte enables.
- o_snp_resp_data  out  DATA_W  merged data.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - FSM goes to IDLE.
  - All outputs are 0 except o_snp_req_ready, which is 1 (combinational from IDLE).
  - Retry and backoff counters are cleared; response registers are cleared.
- Reset mid-operation abandons the snoop in flight. No response is emitted for it.
- IDLE:
  - o_snp_req_ready=1.
  - On valid&ready, latch paddr and go to ISSUE. Retry count is 0.
- ISSUE (1 cycle):
  - o_l1d_s0_valid and o_stq_s0_valid are both 1, driven with the latched paddr.
  - Next state is WAIT.
- WAIT (exactly 1 cycle; s1 is expected the cycle after s0):
  - If i_l1d_s1_valid=0 or status=CONFLICT, treat as conflict:
    - If retry count is below RETRY_MAX, increment it, load the backoff counter with BACKOFF, and go to BACKOFF.
    - Otherwise go to RESP with status CONFLICT and be/data=0.
  - Otherwise merge byte-wise. For each byte b:
    - data[b] = stq_be[b] ? stq_data[b] : l1d_data[b].
    - be[b] = stq_be[b] | (l1d_hit & l1d_be[b]).
    - stq_be and stq_data are treated as 0 when i_stq_s1_valid=0.
  - Merged status is HIT if the L1D hit or any stq_be bit is set; else MISS.
  - Register the merged result and go to RESP.
- BACKOFF:
  - Decrement the backoff counter each cycle.
  - When the counter is 1, go to ISSUE. Exactly BACKOFF cycles elapse with no probe.
- RESP:
  - o_snp_resp_valid=1. Status, be and data are stable until the handshake.
  - On i_snp_resp_ready, go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake, because ready depends only on state.
- Latency from request accept to resp_valid:
  - 3 cycles with no conflict (accept→ISSUE→WAIT→RESP).
  - Each retry adds BACKOFF+2 cycles.
- STQ responses are never conflict-checked. Stray s1 valids outside WAIT are ignored.
- Only one snoop is in flight at a time. No queueing.

Test Plan:
- Clean L1D hit: request paddr 0x8000_0040, L1D HIT be=0xFFFF data=0x1111…, STQ be=0 → resp 3 cycles after accept; status HIT, be=0xFFFF, data=L1D data.
- STQ merge over miss: L1D MISS, STQ be=0x000F data low word 0xDEADBEEF → status HIT, be=0x000F, data[31:0]=0xDEADBEEF, upper bytes 0.
- Partial overlay on hit: L1D HIT data all 0xAA, STQ be=0x8001 with bytes 0x55 → bytes 0 and 15 =0x55, others 0xAA; be=0xFFFF.
- Single conflict: first WAIT sees CONFLICT, second sees HIT → second s0 pulse exactly 6 cycles after the first; status HIT.
- Abort: CONFLICT on all 8 probes → 8 s0 pulses, then status CONFLICT, be=0, data=0.
- Backpressure and reset: hold i_snp_resp_ready=0 for 5 cycles → resp fields stable and req_ready=0; assert i_reset in BACKOFF → next cycle IDLE, no response, req_ready=1.

Source files
------------

// File: rtl/msrh_l1d_snoop_merge_unit.sv
// Coherence snoop front-end: probes L1D and STQ together, retries on L1D conflict
// with a fixed backoff, and returns one response with STQ bytes merged over L1D bytes.
module msrh_l1d_snoop_merge_unit #(
   parameter int PADDR_W   = 56,
   parameter int DATA_W    = 128,
   parameter int BACKOFF   = 4,
   parameter int RETRY_MAX = 7
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_snp_req_valid,
   output logic                  o_snp_req_ready,
   input  logic [PADDR_W-1:0]    i_snp_req_paddr,
   output logic                  o_l1d_s0_valid,
   output logic [PADDR_W-1:0]    o_l1d_s0_paddr,
   input  logic                  i_l1d_s1_valid,
   input  logic [1:0]            i_l1d_s1_status,
   input  logic [DATA_W/8-1:0]   i_l1d_s1_be,
   input  logic [DATA_W-1:0]     i_l1d_s1_data,
   output logic                  o_stq_s0_valid,
   output logic [PADDR_W-1:0]    o_stq_s0_paddr,
   input  logic                  i_stq_s1_valid,
   input  logic [DATA_W/8-1:0]   i_stq_s1_be,
   input  logic [DATA_W-1:0]     i_stq_s1_data,
   output logic                  o_snp_resp_valid,
   input  logic                  i_snp_resp_ready,
   output logic [1:0]            o_snp_resp_status,
   output logic [DATA_W/8-1:0]   o_snp_resp_be,
   output logic [DATA_W-1:0]     o_snp_resp_data
);

   localparam int BE_W    = DATA_W / 8;
   localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam int BOFF_W  = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);

   localparam logic [1:0] STAT_HIT      = 2'd1;
   localparam logic [1:0] STAT_CONFLICT = 2'd2;
   localparam logic [1:0] STAT_MISS     = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_BACKOFF = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [PADDR_W-1:0]   r_paddr;
   logic [RETRY_W-1:0]   r_retry;
   logic [BOFF_W-1:0]    r_boff;
   logic [1:0]           r_resp_status;
   logic [BE_W-1:0]      r_resp_be;
   logic [DATA_W-1:0]    r_resp_data;

   logic                 w_conflict;
   logic                 w_can_retry;
   logic                 w_l1d_hit;
   logic [BE_W-1:0]      w_stq_be;
   logic [DATA_W-1:0]    w_stq_data;
   logic [BE_W-1:0]      w_merge_be;
   logic [DATA_W-1:0]    w_merge_data;
   logic [1:0]           w_merge_status;

   // Both handshakes complete on a cycle where valid and ready are high together;
   // ready and valid on each side are functions of state only.
   assign o_snp_req_ready   = (r_state == S_IDLE);
   assign o_l1d_s0_valid    = (r_state == S_ISSUE);
   assign o_stq_s0_valid    = (r_state == S_ISSUE);
   assign o_l1d_s0_paddr    = r_paddr;
   assign o_stq_s0_paddr    = r_paddr;
   assign o_snp_resp_valid  = (r_state == S_RESP);
   assign o_snp_resp_status = r_resp_status;
   assign o_snp_resp_be     = r_resp_be;
   assign o_snp_resp_data   = r_resp_data;

   // A missing L1D response counts the same as an explicit conflict.
   assign w_conflict  = !i_l1d_s1_valid || (i_l1d_s1_status == STAT_CONFLICT);
   assign w_can_retry = (r_retry < RETRY_W'(RETRY_MAX));
   assign w_l1d_hit   = (i_l1d_s1_status == STAT_HIT);
   assign w_stq_be    = i_stq_s1_valid ? i_stq_s1_be   : '0;
   assign w_stq_data  = i_stq_s1_valid ? i_stq_s1_data : '0;

   always_comb begin
      w_merge_be   = '0;
      w_merge_data = '0;
      for (int b = 0; b < BE_W; b++) begin
         w_merge_data[b*8 +: 8] = w_stq_be[b] ? w_stq_data[b*8 +: 8] : i_l1d_s1_data[b*8 +: 8];
         w_merge_be[b]          = w_stq_be[b] | (w_l1d_hit & i_l1d_s1_be[b]);
      end
   end

   assign w_merge_status = (w_l1d_hit || (|w_stq_be)) ? STAT_HIT : STAT_MISS;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (i_snp_req_valid) w_next_state = S_ISSUE;
         S_ISSUE:   w_next_state = S_WAIT;
         S_WAIT:    w_next_state = (w_conflict && w_can_retry) ? S_BACKOFF : S_RESP;
         S_BACKOFF: if (r_boff <= BOFF_W'(1)) w_next_state = S_ISSUE;
         S_RESP:    if (i_snp_resp_ready) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_paddr       <= '0;
         r_retry       <= '0;
         r_boff        <= '0;
         r_resp_status <= '0;
         r_resp_be     <= '0;
         r_resp_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_snp_req_valid) begin
                  r_paddr <= i_snp_req_paddr;
                  r_retry <= '0;
               end
            end
            S_WAIT: begin
               if (w_conflict) begin
                  if (w_can_retry) begin
                     r_retry <= r_retry + RETRY_W'(1);
                     r_boff  <= BOFF_W'(BACKOFF);
                  end else begin
                     r_resp_status <= STAT_CONFLICT;
                     r_resp_be     <= '0;
                     r_resp_data   <= '0;
                  end
               end else begin
                  r_resp_status <= w_merge_status;
                  r_resp_be     <= w_merge_be;
                  r_resp_data   <= w_merge_data;
               end
            end
            S_BACKOFF: r_boff <= r_boff - BOFF_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_msrh_l1d_snoop_merge_unit.sv
// Self-checking bench for msrh_l1d_snoop_merge_unit: scripted and random snoops
// against a timing/merge reference model derived from the snoop protocol rules.
module tb_msrh_l1d_snoop_merge_unit;

  localparam int PW = 56;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int BOFF = 4;
  localparam int RMAX = 7;
  localparam int RW = 2 + BW + DW;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_ready;
  logic [PW-1:0] req_paddr;
  logic l1d_s0_valid;
  logic [PW-1:0] l1d_s0_paddr;
  logic l1d_s1_valid;
  logic [1:0] l1d_s1_status;
  logic [BW-1:0] l1d_s1_be;
  logic [DW-1:0] l1d_s1_data;
  logic stq_s0_valid;
  logic [PW-1:0] stq_s0_paddr;
  logic stq_s1_valid;
  logic [BW-1:0] stq_s1_be;
  logic [DW-1:0] stq_s1_data;
  logic resp_valid;
  logic resp_ready;
  logic [1:0] resp_status;
  logic [BW-1:0] resp_be;
  logic [DW-1:0] resp_data;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  msrh_l1d_snoop_merge_unit #(
    .PADDR_W(PW), .DATA_W(DW), .BACKOFF(BOFF), .RETRY_MAX(RMAX)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_snp_req_valid(req_valid),
    .o_snp_req_ready(req_ready),
    .i_snp_req_paddr(req_paddr),
    .o_l1d_s0_valid(l1d_s0_valid),
    .o_l1d_s0_paddr(l1d_s0_paddr),
    .i_l1d_s1_valid(l1d_s1_valid),
    .i_l1d_s1_status(l1d_s1_status),
    .i_l1d_s1_be(l1d_s1_be),
    .i_l1d_s1_data(l1d_s1_data),
    .o_stq_s0_valid(stq_s0_valid),
    .o_stq_s0_paddr(stq_s0_paddr),
    .i_stq_s1_valid(stq_s1_valid),
    .i_stq_s1_be(stq_s1_be),
    .i_stq_s1_data(stq_s1_data),
    .o_snp_resp_valid(resp_valid),
    .i_snp_resp_ready(resp_ready),
    .o_snp_resp_status(resp_status),
    .o_snp_resp_be(resp_be),
    .o_snp_resp_data(resp_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: final merged response from the snoop rules
  function automatic logic [RW-1:0] model(input int n_conf, input logic [1:0] st,
                                          input logic [BW-1:0] lbe, input logic [DW-1:0] ldata,
                                          input logic sv, input logic [BW-1:0] sbe_in,
                                          input logic [DW-1:0] sdata_in);
    logic [BW-1:0] sbe;
    logic [DW-1:0] sdata;
    logic [DW-1:0] mask;
    logic hit;
    if (n_conf > RMAX) return {2'd2, {BW{1'b0}}, {DW{1'b0}}};
    sbe = sv ? sbe_in : '0;
    sdata = sv ? sdata_in : '0;
    for (int b = 0; b < BW; b++) mask[b*8 +: 8] = {8{sbe[b]}};
    hit = (st == 2'd1);
    return {((hit || sbe != 0) ? 2'd1 : 2'd3), sbe | (hit ? lbe : '0), (sdata & mask) | (ldata & ~mask)};
  endfunction

  function automatic bit is_probe(input int k, input int n_probes);
    if (k < 1) return 1'b0;
    return ((k - 1) % (BOFF + 2) == 0) && ((k - 1) / (BOFF + 2) < n_probes);
  endfunction

  task automatic drive_stray();
    l1d_s1_valid = 1'($urandom_range(0, 1));
    l1d_s1_status = 2'($urandom_range(0, 3));
    l1d_s1_be = BW'($urandom);
    l1d_s1_data = {$urandom, $urandom, $urandom, $urandom};
    stq_s1_valid = 1'($urandom_range(0, 1));
    stq_s1_be = BW'($urandom);
    stq_s1_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // driver + per-cycle checks for one snoop; n_conf conflicting probes precede the final one
  task automatic run_snoop(input string name, input logic [PW-1:0] paddr, input int n_conf,
                           input logic [1:0] st, input logic [BW-1:0] lbe, input logic [DW-1:0] ldata,
                           input logic sv, input logic [BW-1:0] sbe, input logic [DW-1:0] sdata,
                           input int hold);
    int nretry;
    int n_probes;
    int resp_k;
    int idx;
    int waited;
    logic [RW-1:0] exp_r;
    nretry = (n_conf > RMAX) ? RMAX : n_conf;
    n_probes = nretry + 1;
    resp_k = 3 + nretry * (BOFF + 2);
    exp_q.push_back(model(n_conf, st, lbe, ldata, sv, sbe, sdata));
    exp_r = exp_q.pop_front();

    @(negedge clk);
    req_valid = 1'b1;
    req_paddr = paddr;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);

    for (int k = 1; k <= resp_k + hold; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_paddr = PW'({$urandom, $urandom});
      checks++;
      if (l1d_s0_valid !== is_probe(k, n_probes) || stq_s0_valid !== is_probe(k, n_probes)) begin
        errors++;
        $display("FAIL %s s0_valid k=%0d: got l1d=%b stq=%b want %b", name, k, l1d_s0_valid,
                 stq_s0_valid, is_probe(k, n_probes));
      end
      if (is_probe(k, n_probes)) begin
        checks++;
        if (l1d_s0_paddr !== paddr || stq_s0_paddr !== paddr) begin
          errors++;
          $display("FAIL %s s0_paddr: got %h/%h want %h", name, l1d_s0_paddr, stq_s0_paddr, paddr);
        end
      end
      checks++;
      if (resp_valid !== (k >= resp_k)) begin
        errors++;
        $display("FAIL %s resp_valid k=%0d: got %b want %b", name, k, resp_valid, k >= resp_k);
      end
      if (is_probe(k - 1, n_probes)) begin
        idx = (k - 2) / (BOFF + 2);
        drive_stray();
        if (idx < n_conf) begin
          if ($urandom_range(0, 1) == 1) l1d_s1_valid = 1'b0;
          else begin
            l1d_s1_valid = 1'b1;
            l1d_s1_status = 2'd2;
          end
        end else begin
          l1d_s1_valid = 1'b1;
          l1d_s1_status = st;
          l1d_s1_be = lbe;
          l1d_s1_data = ldata;
          stq_s1_valid = sv;
          stq_s1_be = sbe;
          stq_s1_data = sdata;
        end
      end else begin
        drive_stray();
      end
      if (k >= resp_k) begin
        checks++;
        if ({resp_status, resp_be, resp_data} !== exp_r || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s resp k=%0d: got st=%0d be=%h data=%h rdy=%b want st=%0d be=%h data=%h rdy=0",
                   name, k, resp_status, resp_be, resp_data, req_ready,
                   exp_r[RW-1 -: 2], exp_r[DW +: BW], exp_r[DW-1:0]);
        end
        resp_ready = (k == resp_k + hold);
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after handshake: got valid=%b ready=%b want 0/1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_paddr = '0;
    resp_ready = 1'b0;
    drive_stray();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || l1d_s0_valid !== 1'b0 || stq_s0_valid !== 1'b0 || resp_valid !== 1'b0 ||
        l1d_s0_paddr !== '0 || stq_s0_paddr !== '0 || resp_status !== 2'd0 || resp_be !== '0 ||
        resp_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b s0=%b/%b rv=%b st=%0d be=%h want rdy=1 rest 0",
               req_ready, l1d_s0_valid, stq_s0_valid, resp_valid, resp_status, resp_be);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_hit();
    run_snoop("clean_hit", 56'h0000_8000_0040, 0, 2'd1, 16'hFFFF, {16{8'h11}}, 1'b1, 16'h0000,
              {$urandom, $urandom, $urandom, $urandom}, 0);
  endtask

  task automatic test_stq_over_miss();
    run_snoop("stq_over_miss", 56'h0000_8000_0080, 0, 2'd3, 16'h0000, '0, 1'b1, 16'h000F,
              {96'h0, 32'hDEADBEEF}, 0);
  endtask

  task automatic test_partial_overlay();
    logic [DW-1:0] sd;
    sd = {$urandom, $urandom, $urandom, $urandom};
    sd[7:0] = 8'h55;
    sd[127:120] = 8'h55;
    run_snoop("partial_overlay", 56'h0000_8000_00C0, 0, 2'd1, 16'hFFFF, {16{8'hAA}}, 1'b1, 16'h8001, sd, 0);
  endtask

  task automatic test_single_conflict();
    run_snoop("single_conflict", 56'h0000_1234_5600, 1, 2'd1, 16'h0FF0, {4{32'hCAFEF00D}}, 1'b0,
              16'hFFFF, {4{32'h01234567}}, 0);
  endtask

  task automatic test_abort();
    run_snoop("abort", 56'h00AB_CDEF_0100, 8, 2'd1, 16'hFFFF, {16{8'h77}}, 1'b1, 16'h00FF, {16{8'h99}}, 0);
  endtask

  task automatic test_backpressure();
    run_snoop("backpressure", 56'h0000_0000_0FC0, 0, 2'd3, 16'hFFFF, {16{8'h3C}}, 1'b1, 16'hA5A5,
              {$urandom, $urandom, $urandom, $urandom}, 5);
  endtask

  task automatic test_reset_mid_backoff();
    @(negedge clk);
    req_valid = 1'b1;
    req_paddr = 56'h0000_0DEA_D000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    l1d_s1_valid = 1'b1;
    l1d_s1_status = 2'd2;
    @(negedge clk);
    drive_stray();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || l1d_s0_valid !== 1'b0 || stq_s0_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_backoff: got rdy=%b rv=%b s0=%b/%b want 1/0/0/0",
               req_ready, resp_valid, l1d_s0_valid, stq_s0_valid);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_stray();
      checks++;
      if (resp_valid !== 1'b0 || l1d_s0_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_backoff_quiet cyc=%0d: got rv=%b s0=%b rdy=%b want 0/0/1",
                 i, resp_valid, l1d_s0_valid, req_ready);
      end
    end
  endtask

  task automatic test_random();
    int nc;
    int r;
    logic [1:0] st;
    for (int i = 0; i < 40; i++) begin
      nc = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 2);
      r = $urandom_range(0, 2);
      st = (r == 0) ? 2'd0 : ((r == 1) ? 2'd1 : 2'd3);
      run_snoop("random", PW'({$urandom, $urandom}), nc, st, BW'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                BW'($urandom & $urandom), {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_clean_hit();
    test_stq_over_miss();
    test_partial_overlay();
    test_single_conflict();
    test_abort();
    test_backpressure();
    test_reset_mid_backoff();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
